// File: rtl/rv32i_mc_control_unit.sv
// rv32i_mc_control_unit
// Multicycle sequencer for the RV32I datapath. A Moore FSM walks each
// instruction through FETCH, DECODE and an opcode-specific EXE state, with
// extra MEM/WB states for stores and loads. All control outputs are a
// decode of the current state plus fields of the instruction word.
//
// Optional feature macro: BUS_HANDSHAKE_EN
//   defined   -> adds busReady/busReq; S_MEM and L_MEM wait for busReady.
//   undefined -> S_MEM and L_MEM are single-cycle, no handshake ports.

module rv32i_mc_control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instrCode,
`ifdef BUS_HANDSHAKE_EN
    input  logic        busReady,
`endif
    output logic        PCEn,
    output logic        regFileWe,
    output logic [3:0]  aluControl,
    output logic        aluSrcMuxSel,
    output logic [2:0]  RFWDSrcMuxSel,
    output logic        branch,
    output logic        jal,
    output logic        jalr,
    output logic        busWe,
`ifdef BUS_HANDSHAKE_EN
    output logic        busReq,
`endif
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        R_EXE  = 4'd2,
        I_EXE  = 4'd3,
        B_EXE  = 4'd4,
        LU_EXE = 4'd5,
        AU_EXE = 4'd6,
        J_EXE  = 4'd7,
        JL_EXE = 4'd8,
        S_EXE  = 4'd9,
        S_MEM  = 4'd10,
        L_EXE  = 4'd11,
        L_MEM  = 4'd12,
        L_WB   = 4'd13
    } stateT;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_B  = 7'b1100011;
    localparam logic [6:0] OP_LU = 7'b0110111;
    localparam logic [6:0] OP_AU = 7'b0010111;
    localparam logic [6:0] OP_J  = 7'b1101111;
    localparam logic [6:0] OP_JL = 7'b1100111;
    localparam logic [6:0] OP_S  = 7'b0100011;
    localparam logic [6:0] OP_L  = 7'b0000011;

    localparam logic [2:0] WD_ALU  = 3'd0;
    localparam logic [2:0] WD_LOAD = 3'd1;
    localparam logic [2:0] WD_IMM  = 3'd2;
    localparam logic [2:0] WD_AUPC = 3'd3;
    localparam logic [2:0] WD_PC4  = 3'd4;

    localparam logic [3:0] ALU_ADD = 4'b0000;

    stateT      state_q;
    stateT      state_d;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       bit30;
    logic       memDone;
    logic       unusedInstrBits;

    assign opcode = instrCode[6:0];
    assign funct3 = instrCode[14:12];
    assign bit30  = instrCode[30];
    assign state  = state_q;

    // Instruction bits the sequencer has no use for (register indices, imm).
    assign unusedInstrBits = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

`ifdef BUS_HANDSHAKE_EN
    assign memDone = busReady;
`else
    assign memDone = 1'b1;
`endif

    // State register; reset pulls the sequencer back to FETCH at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection: opcode dispatch in DECODE, memory states wait on the bus.
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_R:    state_d = R_EXE;
                    OP_I:    state_d = I_EXE;
                    OP_B:    state_d = B_EXE;
                    OP_LU:   state_d = LU_EXE;
                    OP_AU:   state_d = AU_EXE;
                    OP_J:    state_d = J_EXE;
                    OP_JL:   state_d = JL_EXE;
                    OP_S:    state_d = S_EXE;
                    OP_L:    state_d = L_EXE;
                    default: state_d = FETCH;
                endcase
            end
            S_EXE:   state_d = S_MEM;
            S_MEM:   state_d = memDone ? FETCH : S_MEM;
            L_EXE:   state_d = L_MEM;
            L_MEM:   state_d = memDone ? L_WB : L_MEM;
            L_WB:    state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Moore output decode from the current state and instruction fields.
    always_comb begin
        PCEn          = 1'b0;
        regFileWe     = 1'b0;
        aluControl    = ALU_ADD;
        aluSrcMuxSel  = 1'b0;
        RFWDSrcMuxSel = WD_ALU;
        branch        = 1'b0;
        jal           = 1'b0;
        jalr          = 1'b0;
        busWe         = 1'b0;
`ifdef BUS_HANDSHAKE_EN
        busReq        = 1'b0;
`endif
        case (state_q)
            FETCH: PCEn = 1'b1;
            R_EXE: begin
                aluControl    = {bit30, funct3};
                RFWDSrcMuxSel = WD_ALU;
                regFileWe     = 1'b1;
            end
            I_EXE: begin
                aluControl    = {(funct3 == 3'b101) ? bit30 : 1'b0, funct3};
                aluSrcMuxSel  = 1'b1;
                RFWDSrcMuxSel = WD_ALU;
                regFileWe     = 1'b1;
            end
            B_EXE: begin
                aluControl = {1'b0, funct3};
                branch     = 1'b1;
            end
            LU_EXE: begin
                RFWDSrcMuxSel = WD_IMM;
                regFileWe     = 1'b1;
            end
            AU_EXE: begin
                RFWDSrcMuxSel = WD_AUPC;
                regFileWe     = 1'b1;
            end
            J_EXE: begin
                jal           = 1'b1;
                RFWDSrcMuxSel = WD_PC4;
                regFileWe     = 1'b1;
            end
            JL_EXE: begin
                jal           = 1'b1;
                jalr          = 1'b1;
                RFWDSrcMuxSel = WD_PC4;
                regFileWe     = 1'b1;
            end
            S_EXE, L_EXE: begin
                aluControl   = ALU_ADD;
                aluSrcMuxSel = 1'b1;
            end
            S_MEM: begin
                busWe        = 1'b1;
                aluSrcMuxSel = 1'b1;
`ifdef BUS_HANDSHAKE_EN
                busReq       = 1'b1;
`endif
            end
            L_MEM: begin
                aluSrcMuxSel = 1'b1;
`ifdef BUS_HANDSHAKE_EN
                busReq       = 1'b1;
`endif
            end
            L_WB: begin
                RFWDSrcMuxSel = WD_LOAD;
                regFileWe     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/rv32i_mc_control_unit.md
# rv32i_mc_control_unit

Multicycle sequencer for the RV32I datapath. It decodes the current instruction word and steps a Moore FSM through FETCH, DECODE, EXECUTE and, for loads and stores, MEM and WB. Per state it drives PC enable, register-file write, ALU control, mux selects, branch/jump qualifiers and the data-bus write strobe. It sits beside the datapath and shares its instruction-word input.

## Interface
- No parameters.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; forces FETCH.
- instrCode  in  32  current instruction word (combinational from instruction memory at PC).
- busReady  in  1  data-bus ready; present only with BUS_HANDSHAKE_EN.
- PCEn  out  1  PC register load enable.
- regFileWe  out  1  register-file write enable.
- aluControl  out  4  ALU operation / branch compare select.
- aluSrcMuxSel  out  1  ALU B operand: 0 = rs2 data, 1 = immediate.
- RFWDSrcMuxSel  out  3  writeback source: 0 = ALU, 1 = load data, 2 = imm, 3 = PC+imm, 4 = PC+4.
- branch  out  1  conditional-branch qualifier.
- jal  out  1  unconditional PC+imm / rs1+imm select.
- jalr  out  1  adder base = rs1.
- busWe  out  1  data-bus write strobe.
- busReq  out  1  data-bus access request; present only with BUS_HANDSHAKE_EN.
- state  out  4  current FSM state, for debug and verification.

## Operation
- State encodings:
  - FETCH = 0, DECODE = 1, R_EXE = 2, I_EXE = 3, B_EXE = 4.
  - LU_EXE = 5, AU_EXE = 6, J_EXE = 7, JL_EXE = 8.
  - S_EXE = 9, S_MEM = 10, L_EXE = 11, L_MEM = 12, L_WB = 13.
  - Codes 14 and 15 recover to FETCH.
- Transitions:
  - FETCH -> DECODE.
  - DECODE -> the EXE state selected by opcode[6:0]: R = 0110011, I = 0010011, B = 1100011, LU = 0110111, AU = 0010111, J = 1101111, JL = 1100111, S = 0100011, L = 0000011.
  - Any other opcode -> FETCH with no writes; PC advances by 4.
  - S_EXE -> S_MEM -> FETCH.
  - L_EXE -> L_MEM -> L_WB -> FETCH.
  - All other EXE states -> FETCH.
- Outputs are a pure Moore decode of state plus instrCode fields. Every output defaults to 0 in every state not listed below.
- FETCH: PCEn = 1. The PC loads the next-PC value the datapath registered at the end of the previous instruction's last state.
- R_EXE: aluControl = {instr[30], funct3}, aluSrcMuxSel = 0, RFWDSrcMuxSel = 0, regFileWe = 1.
- I_EXE:
  - aluControl = {funct3 == 101 ? instr[30] : 0, funct3}.
  - aluSrcMuxSel = 1, RFWDSrcMuxSel = 0, regFileWe = 1.
- B_EXE: aluControl = {0, funct3}, aluSrcMuxSel = 0, branch = 1.
- LU_EXE: RFWDSrcMuxSel = 2, regFileWe = 1.
- AU_EXE: RFWDSrcMuxSel = 3, regFileWe = 1.
- J_EXE: jal = 1, RFWDSrcMuxSel = 4, regFileWe = 1.
- JL_EXE: jal = 1, jalr = 1, RFWDSrcMuxSel = 4, regFileWe = 1.
- S_EXE and L_EXE: aluControl = 0000 (ADD), aluSrcMuxSel = 1.
- S_MEM: busWe = 1, aluSrcMuxSel = 1.
- L_MEM: aluSrcMuxSel = 1.
- L_WB: RFWDSrcMuxSel = 1, regFileWe = 1.
- regFileWe is never 1 in FETCH, DECODE, B_EXE, S_EXE, S_MEM, L_EXE or L_MEM.

## Timing
- Cycles per instruction, FETCH to FETCH:
  - R, I, B, LU, AU, J and JL: 3.
  - S: 4.
  - L: 5.
- Reset values: state = FETCH (0). PCEn = 1, because FETCH is active during reset; the PC itself is held by reset. All other outputs are 0.
- Reset deassertion: the first rising edge moves FETCH -> DECODE.
- Reset asserted mid-instruction: immediate return to FETCH. No pending write or strobe completes after reset rises.
- busWe is exactly one cycle per store without the macro.
- PCEn is exactly one cycle per instruction.

## Configuration
- BUS_HANDSHAKE_EN defined:
  - busReady input and busReq output exist.
  - busReq = 1 in S_MEM and L_MEM.
  - S_MEM and L_MEM hold, with all outputs unchanged, until a cycle with busReady = 1; they exit at that edge.
  - busWe stays asserted for the whole S_MEM dwell.
- BUS_HANDSHAKE_EN undefined: no busReady or busReq ports; S_MEM and L_MEM are always single-cycle.

## Test plan
- Reset, then ADD x3,x1,x2 (0x002081B3):
  - During reset: state = 0, PCEn = 1, others 0.
  - Sequence: FETCH, DECODE, R_EXE, FETCH on the 4th cycle.
  - R_EXE: aluControl = 0000, RFWDSrcMuxSel = 0, regFileWe = 1.
- ALU control decode:
  - SUB 0x402081B3 -> 1000.
  - SRAI x3,x1,4 (0x4040D193) -> 1101 with aluSrcMuxSel = 1.
  - ADDI x3,x1,-1024 (0xC0008193) -> 0000, since bit 30 is ignored.
- LW x5,8(x1) (0x0080A283):
  - States: 0, 1, 11, 12, 13, then 0.
  - regFileWe = 1 only in L_WB, with RFWDSrcMuxSel = 1.
- SW x2,4(x1) (0x0020A223):
  - States: 0, 1, 9, 10, then 0.
  - busWe = 1 for exactly one cycle; regFileWe is never 1.
- BNE x1,x2,+8 (0x00209463) and JALR x1,0(x5) (0x000280E7):
  - BNE: B_EXE with branch = 1, aluControl = 0001, regFileWe = 0.
  - JALR: JL_EXE with jal = 1, jalr = 1, RFWDSrcMuxSel = 4, regFileWe = 1.
  - Illegal opcode 0x0000007F -> FETCH after DECODE, no writes.
- With BUS_HANDSHAKE_EN:
  - LW with busReady low for 3 cycles stays in L_MEM for 4 cycles with busReq = 1, then goes to L_WB.
  - Reset asserted during L_MEM -> state = 0 immediately, busReq = 0, with no write.
